// File: rtl/inert_intf_gen_if.sv
// SPI command channel between the sensor sequencer and an external 16-bit SPI master.
// The sequencer drives wrt/cmd for one cycle; the master returns done with the read byte.
interface inert_intf_gen_if;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [7:0]  rd_data;

   modport master (output wrt, cmd, input done, rd_data);
   modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/inert_intf_gen.sv
// Sensor sequencer: power-up wait, init writes, then one byte-by-byte sample-set read per data-ready.
// wrt/cmd are decoded from registered state in the same cycle as done; one SPI op in flight, no backpressure.
module inert_intf_gen #(
   parameter int                      NUM_INIT  = 4,
   parameter logic [16*NUM_INIT-1:0]  INIT_CMDS = {16'h1460, 16'h1150, 16'h1053, 16'h0D02},
   parameter int                      NUM_WORDS = 2,
   parameter logic [16*NUM_WORDS-1:0] RD_ADDRS  = {8'hAD, 8'hAC, 8'hA3, 8'hA2},
   parameter int                      PWRUP_W   = 16,
   parameter int                      GAP_W     = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     INT,
   input  logic                     reinit,
   inert_intf_gen_if.master         spi,
   output logic [16*NUM_WORDS-1:0]  data,
   output logic                     vld,
   output logic                     init_done,
   output logic                     ovr
);

   typedef enum logic [1:0] {PWRUP, INIT, WAIT, READ} state_t;

   localparam int         LAST   = 2*NUM_WORDS-1;
   localparam logic [2:0] LAST_B = 3'(LAST);
   localparam logic [3:0] NUM_I  = 4'(NUM_INIT);

   state_t                  state, state_nxt;
   logic [PWRUP_W-1:0]      timer;
   logic [3:0]              init_idx;
   logic [2:0]              byte_idx, byte_nxt;
   logic [16*NUM_WORDS-1:0] shadow;
   logic                    int_ff1, int_s, int_s_d;
   logic                    reinit_pend;
   logic                    pwr_hit, gap_hit, last_byte, go_init;
   logic                    wrt;
   logic [15:0]             cmd;

   assign pwr_hit   = &timer;
   assign gap_hit   = &timer[GAP_W-1:0];
   assign byte_nxt  = byte_idx + 3'd1;
   assign last_byte = (byte_idx == LAST_B);
   assign go_init   = reinit | reinit_pend;

   assign spi.wrt = wrt;
   assign spi.cmd = cmd;

   always_comb begin
      state_nxt = state;
      wrt       = 1'b0;
      cmd       = 16'h0000;
      case (state)
         PWRUP: begin
            if (pwr_hit) begin
               wrt       = 1'b1;
               cmd       = INIT_CMDS[15:0];
               state_nxt = INIT;
            end
         end
         INIT: begin
            if (gap_hit) begin
               if (init_idx < NUM_I) begin
                  wrt = 1'b1;
                  cmd = INIT_CMDS[16*init_idx +: 16];
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (reinit) begin
               state_nxt = INIT;
            end else if (int_s) begin
               wrt       = 1'b1;
               cmd       = {RD_ADDRS[7:0], 8'h00};
               state_nxt = READ;
            end
         end
         READ: begin
            if (spi.done) begin
               if (!last_byte) begin
                  wrt = 1'b1;
                  cmd = {RD_ADDRS[8*byte_nxt +: 8], 8'h00};
               end else begin
                  state_nxt = go_init ? INIT : WAIT;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= PWRUP;
         timer       <= '0;
         init_idx    <= '0;
         byte_idx    <= '0;
         shadow      <= '0;
         data        <= '0;
         vld         <= 1'b0;
         init_done   <= 1'b0;
         ovr         <= 1'b0;
         reinit_pend <= 1'b0;
         int_ff1     <= 1'b0;
         int_s       <= 1'b0;
         int_s_d     <= 1'b0;
      end else begin
         int_ff1 <= INT;
         int_s   <= int_ff1;
         int_s_d <= int_s;
         state   <= state_nxt;
         vld     <= 1'b0;

         // Every SPI start and every state change restarts the gap/power-up count.
         if (wrt || (state_nxt != state)) timer <= '0;
         else                             timer <= timer + 1'b1;

         case (state)
            PWRUP: begin
               if (pwr_hit) init_idx <= 4'd1;
            end
            INIT: begin
               if (gap_hit) begin
                  if (init_idx < NUM_I) init_idx  <= init_idx + 4'd1;
                  else                  init_done <= 1'b1;
               end
            end
            WAIT: begin
               if (reinit) begin
                  init_done <= 1'b0;
                  init_idx  <= '0;
                  ovr       <= 1'b0;
               end else if (int_s) begin
                  byte_idx <= '0;
               end
            end
            READ: begin
               if (int_s && !int_s_d) ovr <= 1'b1;
               if (reinit) reinit_pend <= 1'b1;
               if (spi.done) begin
                  shadow[8*byte_idx +: 8] <= spi.rd_data;
                  if (last_byte) begin
                     // The final byte bypasses the shadow so the whole set lands at once.
                     data        <= {spi.rd_data, shadow[8*LAST-1:0]};
                     vld         <= 1'b1;
                     reinit_pend <= 1'b0;
                     if (go_init) begin
                        init_done <= 1'b0;
                        init_idx  <= '0;
                        ovr       <= 1'b0;
                     end
                  end else begin
                     byte_idx <= byte_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inert_intf_gen.sv
// Directed bench: default instance for power-up/init/read/overrun/reinit timing,
// plus a one-word, one-init-command instance with short timers.
module tb_inert_intf_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        int1 = 1'b0, int2 = 1'b0;
   logic        reinit1 = 1'b0, reinit2 = 1'b0;
   logic [31:0] data1;
   logic [15:0] data2;
   logic        vld1, vld2, init_done1, init_done2, ovr1, ovr2;

   int cyc  = 0;
   int nchk = 0;
   int nerr = 0;

   localparam int PWR1 = 65535;
   localparam int GAP1 = 1023;
   localparam int PWR2 = 63;
   localparam int GAP2 = 7;

   inert_intf_gen_if spi1();
   inert_intf_gen_if spi2();

   inert_intf_gen dut1 (
      .clk(clk), .rst(rst), .INT(int1), .reinit(reinit1), .spi(spi1),
      .data(data1), .vld(vld1), .init_done(init_done1), .ovr(ovr1)
   );

   inert_intf_gen #(
      .NUM_INIT(1), .INIT_CMDS(16'h0D02), .NUM_WORDS(1), .RD_ADDRS(16'hB5B4),
      .PWRUP_W(6), .GAP_W(3)
   ) dut2 (
      .clk(clk), .rst(rst), .INT(int2), .reinit(reinit2), .spi(spi2),
      .data(data2), .vld(vld2), .init_done(init_done2), .ovr(ovr2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Returns the cycle number of the next wrt pulse, or -1 when none shows up in time.
   task automatic wait_wrt(input int sel, input int bound, output int at);
      at = -1;
      for (int i = 0; i <= bound; i++) begin
         if (((sel == 1) ? spi1.wrt : spi2.wrt) === 1'b1) begin
            at = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Emulates the SPI master finishing a transfer; returns the same-cycle wrt/cmd.
   task automatic give_byte(input int sel, input logic [7:0] b, output logic w, output logic [15:0] c);
      repeat (3) @(negedge clk);
      if (sel == 1) begin spi1.done = 1'b1; spi1.rd_data = b; end
      else          begin spi2.done = 1'b1; spi2.rd_data = b; end
      #1;
      w = (sel == 1) ? spi1.wrt : spi2.wrt;
      c = (sel == 1) ? spi1.cmd : spi2.cmd;
      @(negedge clk);
      spi1.done = 1'b0;
      spi2.done = 1'b0;
   endtask

   initial begin
      int c0, t, t2, r, tv;
      logic w;
      logic [15:0] c;
      logic [15:0] init_cmds [4];
      init_cmds[0] = 16'h0D02; init_cmds[1] = 16'h1053;
      init_cmds[2] = 16'h1150; init_cmds[3] = 16'h1460;
      spi1.done = 1'b0; spi1.rd_data = 8'h00;
      spi2.done = 1'b0; spi2.rd_data = 8'h00;

      repeat (3) @(negedge clk);
      chk("rst_wrt",  {31'd0, spi1.wrt}, 32'd0);
      chk("rst_cmd",  {16'd0, spi1.cmd}, 32'd0);
      chk("rst_data", data1, 32'd0);
      chk("rst_vld",  {31'd0, vld1}, 32'd0);
      chk("rst_idone", {31'd0, init_done1}, 32'd0);
      chk("rst_ovr",  {31'd0, ovr1}, 32'd0);
      rst = 1'b0;
      c0  = cyc;

      // Small instance: one init write, two byte reads per set.
      wait_wrt(2, 200, t);
      chk("pw2_time", t - c0, PWR2);
      chk("pw2_cmd", {16'd0, spi2.cmd}, 32'h0D02);
      @(negedge clk);
      repeat (GAP2) @(negedge clk);
      chk("init2_single_wrt", {31'd0, spi2.wrt}, 32'd0);
      chk("init2_not_done", {31'd0, init_done2}, 32'd0);
      @(negedge clk);
      chk("init2_done", {31'd0, init_done2}, 32'd1);
      int2 = 1'b1;
      wait_wrt(2, 10, t);
      chk("rd2_cmd0", {16'd0, spi2.cmd}, 32'hB400);
      int2 = 1'b0;
      give_byte(2, 8'h11, w, c);
      chk("rd2_wrt1", {31'd0, w}, 32'd1);
      chk("rd2_cmd1", {16'd0, c}, 32'hB500);
      give_byte(2, 8'h22, w, c);
      chk("rd2_last_nowrt", {31'd0, w}, 32'd0);
      chk("rd2_vld", {31'd0, vld2}, 32'd1);
      chk("rd2_data", {16'd0, data2}, 32'h2211);
      wait_wrt(2, 20, t);
      chk("rd2_two_only", t, -1);

      // Default instance: power-up then four init writes.
      wait_wrt(1, 70000, t);
      chk("pw1_time", t - c0, PWR1);
      chk("pw1_cmd", {16'd0, spi1.cmd}, 32'h0D02);
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         wait_wrt(1, 1100, t2);
         chk("init1_gap", t2 - t, GAP1 + 1);
         chk("init1_cmd", {16'd0, spi1.cmd}, {16'd0, init_cmds[k]});
         t = t2;
      end
      @(negedge clk);
      repeat (GAP1) @(negedge clk);
      chk("idone1_early", {31'd0, init_done1}, 32'd0);
      chk("idone1_nowrt", {31'd0, spi1.wrt}, 32'd0);
      @(negedge clk);
      chk("idone1_set", {31'd0, init_done1}, 32'd1);

      // First sample set.
      int1 = 1'b1;
      wait_wrt(1, 10, t);
      chk("rd1_cmd0", {16'd0, spi1.cmd}, 32'hA200);
      int1 = 1'b0;
      give_byte(1, 8'h34, w, c);
      chk("rd1_cmd1", {15'd0, w, c}, 32'h1A300);
      give_byte(1, 8'h12, w, c);
      chk("rd1_cmd2", {15'd0, w, c}, 32'h1AC00);
      give_byte(1, 8'h78, w, c);
      chk("rd1_cmd3", {15'd0, w, c}, 32'h1AD00);
      give_byte(1, 8'h56, w, c);
      chk("rd1_last", {15'd0, w, c}, 32'h00000);
      chk("rd1_vld", {31'd0, vld1}, 32'd1);
      chk("rd1_data", data1, 32'h5678_1234);
      chk("rd1_ovr", {31'd0, ovr1}, 32'd0);
      @(negedge clk);
      chk("rd1_vld_pulse", {31'd0, vld1}, 32'd0);

      // A stray done while idle must not start or complete anything.
      give_byte(1, 8'hEE, w, c);
      chk("idle_done_wrt", {31'd0, w}, 32'd0);
      chk("idle_done_vld", {31'd0, vld1}, 32'd0);
      chk("idle_done_data", data1, 32'h5678_1234);

      // Second set with an INT re-assertion mid-read.
      int1 = 1'b1;
      wait_wrt(1, 10, t);
      chk("rd2s_cmd0", {16'd0, spi1.cmd}, 32'hA200);
      int1 = 1'b0;
      repeat (4) @(negedge clk);
      int1 = 1'b1;
      repeat (4) @(negedge clk);
      int1 = 1'b0;
      chk("ovr_set", {31'd0, ovr1}, 32'd1);
      give_byte(1, 8'hAA, w, c);
      give_byte(1, 8'hBB, w, c);
      give_byte(1, 8'hCC, w, c);
      chk("no_partial", data1, 32'h5678_1234);
      give_byte(1, 8'hDD, w, c);
      chk("rd2s_vld", {31'd0, vld1}, 32'd1);
      chk("rd2s_data", data1, 32'hDDCC_BBAA);
      chk("ovr_sticky", {31'd0, ovr1}, 32'd1);

      // reinit while idle restarts init without the power-up wait.
      @(negedge clk);
      reinit1 = 1'b1;
      r = cyc;
      @(negedge clk);
      reinit1 = 1'b0;
      chk("reinit_ovr", {31'd0, ovr1}, 32'd0);
      chk("reinit_idone", {31'd0, init_done1}, 32'd0);
      wait_wrt(1, 1100, t);
      chk("reinit_gap", t - r, GAP1 + 1);
      chk("reinit_cmd", {16'd0, spi1.cmd}, 32'h0D02);

      // reinit during INIT is ignored: sequence carries on.
      @(negedge clk);
      reinit1 = 1'b1;
      @(negedge clk);
      reinit1 = 1'b0;
      for (int k = 1; k < 4; k++) begin
         wait_wrt(1, 1100, t2);
         chk("reinit_init_gap", t2 - t, GAP1 + 1);
         chk("reinit_init_cmd", {16'd0, spi1.cmd}, {16'd0, init_cmds[k]});
         t = t2;
         @(negedge clk);
      end
      repeat (GAP1 + 1) @(negedge clk);
      chk("reinit_idone_set", {31'd0, init_done1}, 32'd1);

      // reinit during READ: the set still completes, then INIT.
      int1 = 1'b1;
      wait_wrt(1, 10, t);
      chk("rd3_cmd0", {16'd0, spi1.cmd}, 32'hA200);
      int1 = 1'b0;
      give_byte(1, 8'h01, w, c);
      reinit1 = 1'b1;
      @(negedge clk);
      reinit1 = 1'b0;
      give_byte(1, 8'h02, w, c);
      give_byte(1, 8'h03, w, c);
      give_byte(1, 8'h04, w, c);
      tv = cyc;
      chk("rd3_vld", {31'd0, vld1}, 32'd1);
      chk("rd3_data", data1, 32'h0403_0201);
      chk("rd3_idone", {31'd0, init_done1}, 32'd0);
      @(negedge clk);
      wait_wrt(1, 1100, t);
      chk("rd3_init_gap", t - tv, GAP1);
      chk("rd3_init_cmd", {16'd0, spi1.cmd}, 32'h0D02);

      // Reset mid-transaction on the small instance; a late done is ignored.
      int2 = 1'b1;
      wait_wrt(2, 10, t);
      chk("rst_rd_cmd", {16'd0, spi2.cmd}, 32'hB400);
      int2 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      spi2.done = 1'b1;
      spi2.rd_data = 8'h99;
      #1;
      chk("late_done_wrt", {31'd0, spi2.wrt}, 32'd0);
      @(negedge clk);
      spi2.done = 1'b0;
      chk("late_done_vld", {31'd0, vld2}, 32'd0);
      chk("late_done_data", {16'd0, data2}, 32'd0);
      chk("rst_idone2", {31'd0, init_done2}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

endmodule
